// File: rtl/i2c_tx_ctr.sv
// Purpose: I2C slave transmit sequencer; serialises buffered bytes MSB-first on SDA and tracks ACK/NACK per frame.
// Latency: sda_out updates 1 cycle after next_in; byte/frame/nack pulses 1 cycle after sample_in.
// Backpressure: data_ready_out = buffer empty; a missing byte at load time is replaced by 8'hFF with an underrun pulse.
module i2c_tx_ctr #(
    parameter int FRAME_BYTES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_in,
    input  logic       txen_in,
    input  logic       next_in,
    input  logic       sample_in,
    input  logic       sda_in,
    input  logic [7:0] data_in,
    input  logic       data_valid_in,
    output logic       data_ready_out,
    output logic       sda_out,
    output logic       byteok_out,
    output logic       frameok_out,
    output logic       nack_out,
    output logic       underrun_out
);
    localparam int BCW = $clog2(FRAME_BYTES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_ACK, ST_HOLD} state_t;

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_buf, w_buf_nxt;
    logic [7:0]     r_shreg, w_shreg_nxt;
    logic           r_buf_full, w_buf_full_nxt;
    logic [2:0]     r_bitcnt, w_bitcnt_nxt;
    logic [BCW-1:0] r_bytecnt, w_bytecnt_nxt;
    logic           r_sda, w_sda_nxt;
    logic           r_byteok, w_byteok_nxt;
    logic           r_frameok, w_frameok_nxt;
    logic           r_nack, w_nack_nxt;
    logic           r_underrun, w_underrun_nxt;
    logic           w_load;
    logic           w_hs;
    logic [7:0]     w_load_byte;
    logic [BCW-1:0] w_bytecnt_inc;

    // An empty buffer at load time sends all-ones, which is the released-bus pattern.
    assign w_load_byte    = r_buf_full ? r_buf : 8'hFF;
    assign w_hs           = data_valid_in & ~r_buf_full;
    assign w_bytecnt_inc  = r_bytecnt + BCW'(1);

    assign data_ready_out = ~r_buf_full;
    assign sda_out        = r_sda;
    assign byteok_out     = r_byteok;
    assign frameok_out    = r_frameok;
    assign nack_out       = r_nack;
    assign underrun_out   = r_underrun;

    // Next-state logic: clear dominates, then bus strobes, then the buffer handshake.
    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_shreg_nxt    = r_shreg;
        w_buf_full_nxt = r_buf_full;
        w_bitcnt_nxt   = r_bitcnt;
        w_bytecnt_nxt  = r_bytecnt;
        w_sda_nxt      = r_sda;
        w_byteok_nxt   = 1'b0;
        w_frameok_nxt  = 1'b0;
        w_nack_nxt     = 1'b0;
        w_underrun_nxt = 1'b0;
        w_load         = 1'b0;
        if (clr_in) begin
            w_state_nxt    = ST_IDLE;
            w_bitcnt_nxt   = 3'd0;
            w_bytecnt_nxt  = '0;
            w_buf_full_nxt = 1'b0;
            w_sda_nxt      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_sda_nxt = 1'b1;
                    if (next_in && txen_in) begin
                        w_load = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (next_in) begin
                        if (r_bitcnt != 3'd7) begin
                            w_shreg_nxt  = {r_shreg[6:0], 1'b0};
                            w_bitcnt_nxt = r_bitcnt + 3'd1;
                            w_sda_nxt    = r_shreg[6];
                        end else begin
                            // Release SDA so the master can drive the ACK bit.
                            w_sda_nxt   = 1'b1;
                            w_state_nxt = ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (sample_in) begin
                        if (!sda_in) begin
                            w_byteok_nxt = 1'b1;
                            if (w_bytecnt_inc == BCW'(FRAME_BYTES)) begin
                                w_frameok_nxt = 1'b1;
                                w_bytecnt_nxt = '0;
                            end else begin
                                w_bytecnt_nxt = w_bytecnt_inc;
                            end
                        end else begin
                            w_nack_nxt    = 1'b1;
                            w_bytecnt_nxt = '0;
                            w_state_nxt   = ST_HOLD;
                        end
                    end else if (next_in) begin
                        w_load = 1'b1;
                    end
                end
                ST_HOLD: begin
                    w_sda_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sda_nxt   = 1'b1;
                end
            endcase
            if (w_load) begin
                w_shreg_nxt    = w_load_byte;
                w_sda_nxt      = w_load_byte[7];
                w_underrun_nxt = ~r_buf_full;
                w_bitcnt_nxt   = 3'd0;
                w_buf_full_nxt = 1'b0;
                w_state_nxt    = ST_SHIFT;
            end
            // A handshake is only possible while the buffer was empty, so it
            // refills for the following byte even when it coincides with a load.
            if (w_hs) begin
                w_buf_nxt      = data_in;
                w_buf_full_nxt = 1'b1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_buf      <= 8'h00;
            r_shreg    <= 8'h00;
            r_buf_full <= 1'b0;
            r_bitcnt   <= 3'd0;
            r_bytecnt  <= '0;
            r_sda      <= 1'b1;
            r_byteok   <= 1'b0;
            r_frameok  <= 1'b0;
            r_nack     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_shreg    <= w_shreg_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_bytecnt  <= w_bytecnt_nxt;
            r_sda      <= w_sda_nxt;
            r_byteok   <= w_byteok_nxt;
            r_frameok  <= w_frameok_nxt;
            r_nack     <= w_nack_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end
endmodule

// Purpose: checks that the SCL rising and falling strobes never coincide.
// Latency: evaluated every rising clock edge outside reset.
// Backpressure: none; observation only.
module i2c_tx_ctr_sva (
    input logic clk,
    input logic rst_n,
    input logic next_in,
    input logic sample_in
);
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(next_in && sample_in));
endmodule

bind i2c_tx_ctr i2c_tx_ctr_sva u_sva (
    .clk       (clk),
    .rst_n     (rst_n),
    .next_in   (next_in),
    .sample_in (sample_in)
);

// File: tb/tb_i2c_tx_ctr.sv
// Purpose: self-checking bench for i2c_tx_ctr with randomized bytes, gaps and ACK/NACK.
// Latency: inputs driven on falling edges, outputs observed on the following falling edge.
// Backpressure: bench only hands a byte over while the holding buffer is empty.
module tb_i2c_tx_ctr;
    localparam int FB = 2;

    logic       clk = 1'b0;
    logic       rst_n, clr_in, txen_in, next_in, sample_in, sda_in;
    logic [7:0] data_in;
    logic       data_valid_in;
    logic       data_ready_out, sda_out, byteok_out, frameok_out, nack_out, underrun_out;

    int n_chk  = 0;
    int n_fail = 0;
    int model_cnt = 0;   // bytes ACKed so far in the current frame

    always #5 clk = ~clk;

    i2c_tx_ctr #(.FRAME_BYTES(FB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr_in         (clr_in),
        .txen_in        (txen_in),
        .next_in        (next_in),
        .sample_in      (sample_in),
        .sda_in         (sda_in),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .data_ready_out (data_ready_out),
        .sda_out        (sda_out),
        .byteok_out     (byteok_out),
        .frameok_out    (frameok_out),
        .nack_out       (nack_out),
        .underrun_out   (underrun_out)
    );

    // Reference frame model: returns expected {byteok, frameok, nack} for one ACK slot.
    function automatic logic [2:0] exp_ack(input logic ack);
        if (ack) begin
            model_cnt = model_cnt + 1;
            if (model_cnt == FB) begin
                model_cnt = 0;
                return 3'b110;
            end
            return 3'b100;
        end
        model_cnt = 0;
        return 3'b001;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_next();
        next_in = 1'b1;
        @(negedge clk);
        next_in = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        data_valid_in = 1'b1;
        data_in       = b;
        @(negedge clk);
        data_valid_in = 1'b0;
    endtask

    task automatic clear();
        clr_in = 1'b1;
        @(negedge clk);
        clr_in = 1'b0;
        model_cnt = 0;
    endtask

    // Nine SCL-falling strobes: load, seven shifts, release for ACK.
    task automatic shift_byte(input logic hs_with_load, input logic [7:0] hs_byte,
                              output logic [7:0] seen, output int ur_cnt, output logic ackslot);
        cyc($urandom_range(0, 2));
        next_in = 1'b1;
        if (hs_with_load) begin
            data_valid_in = 1'b1;
            data_in       = hs_byte;
        end
        @(negedge clk);
        next_in       = 1'b0;
        data_valid_in = 1'b0;
        seen[7] = sda_out;
        ur_cnt  = int'(underrun_out);
        txen_in = 1'($urandom);
        for (int i = 6; i >= 0; i--) begin
            cyc($urandom_range(0, 2));
            strobe_next();
            seen[i] = sda_out;
            ur_cnt  = ur_cnt + int'(underrun_out);
        end
        cyc($urandom_range(0, 2));
        strobe_next();
        ackslot = sda_out;
        ur_cnt  = ur_cnt + int'(underrun_out);
    endtask

    task automatic ack_slot(input logic ack, output logic [2:0] p_now, output logic [2:0] p_after);
        cyc($urandom_range(0, 2));
        sda_in    = ~ack;
        sample_in = 1'b1;
        @(negedge clk);
        sample_in = 1'b0;
        sda_in    = 1'b1;
        p_now = {byteok_out, frameok_out, nack_out};
        @(negedge clk);
        p_after = {byteok_out, frameok_out, nack_out};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr_in = 1'b0; txen_in = 1'b1; next_in = 1'b1; sample_in = 1'b0;
        sda_in = 1'b0; data_in = 8'h3C; data_valid_in = 1'b1;
        cyc(2);
        n_chk++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda_out); end
        n_chk++; if ({byteok_out, frameok_out, nack_out, underrun_out} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 0000", {byteok_out, frameok_out, nack_out, underrun_out}); end
        n_chk++; if (data_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", data_ready_out); end
        next_in = 1'b0; data_valid_in = 1'b0; txen_in = 1'b0; sda_in = 1'b1; rst_n = 1'b1;
        cyc(1);
        n_chk++; if ({sda_out, data_ready_out} !== 2'b11) begin
            n_fail++; $display("FAIL reset_release: got sda/ready %b want 11", {sda_out, data_ready_out}); end
    endtask

    task automatic test_single_byte();
        logic [7:0] seen; int ur; logic ak; logic [2:0] pn, pa, e;
        clear();
        txen_in = 1'b1;
        push(8'hA5);
        n_chk++; if (data_ready_out !== 1'b0) begin n_fail++; $display("FAIL single_ready_full: got %b want 0", data_ready_out); end
        shift_byte(1'b0, 8'h00, seen, ur, ak);
        n_chk++; if (seen !== 8'hA5) begin n_fail++; $display("FAIL single_bits: got %h want a5", seen); end
        n_chk++; if (ur !== 0) begin n_fail++; $display("FAIL single_underrun: got %0d want 0", ur); end
        n_chk++; if (ak !== 1'b1) begin n_fail++; $display("FAIL single_ackslot: got %b want 1", ak); end
        n_chk++; if (data_ready_out !== 1'b1) begin n_fail++; $display("FAIL single_ready_empty: got %b want 1", data_ready_out); end
        ack_slot(1'b1, pn, pa);
        e = exp_ack(1'b1);
        n_chk++; if (pn !== e) begin n_fail++; $display("FAIL single_pulses: got %b want %b", pn, e); end
        n_chk++; if (pa !== 3'b000) begin n_fail++; $display("FAIL single_pulse_width: got %b want 000", pa); end
        n_chk++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL single_sda_after_ack: got %b want 1", sda_out); end
    endtask

    task automatic test_full_frame();
        logic [7:0] bytes [3];
        logic [7:0] seen; int ur; logic ak; logic [2:0] pn, pa, e;
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'($urandom);
        clear();
        for (int k = 0; k < 3; k++) begin
            txen_in = 1'b1;
            push(bytes[k]);
            shift_byte(1'b0, 8'h00, seen, ur, ak);
            n_chk++; if (seen !== bytes[k]) begin n_fail++; $display("FAIL frame_bits[%0d]: got %h want %h", k, seen, bytes[k]); end
            ack_slot(1'b1, pn, pa);
            e = exp_ack(1'b1);
            n_chk++; if (pn !== e) begin n_fail++; $display("FAIL frame_pulses[%0d]: got %b want %b", k, pn, e); end
            n_chk++; if (pa !== 3'b000) begin n_fail++; $display("FAIL frame_pulse_width[%0d]: got %b want 000", k, pa); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] seen; int ur; logic ak; logic [2:0] pn, pa, e; logic [7:0] b;
        b = 8'($urandom);
        clear();
        txen_in = 1'b1;
        shift_byte(1'b1, b, seen, ur, ak);
        n_chk++; if (seen !== 8'hFF) begin n_fail++; $display("FAIL underrun_bits: got %h want ff", seen); end
        n_chk++; if (ur !== 1) begin n_fail++; $display("FAIL underrun_count: got %0d want 1", ur); end
        n_chk++; if (data_ready_out !== 1'b0) begin n_fail++; $display("FAIL underrun_hs_kept: got ready %b want 0", data_ready_out); end
        ack_slot(1'b1, pn, pa);
        e = exp_ack(1'b1);
        n_chk++; if (pn !== e) begin n_fail++; $display("FAIL underrun_ack: got %b want %b", pn, e); end
        shift_byte(1'b0, 8'h00, seen, ur, ak);
        n_chk++; if (seen !== b) begin n_fail++; $display("FAIL underrun_next_byte: got %h want %h", seen, b); end
        n_chk++; if (ur !== 0) begin n_fail++; $display("FAIL underrun_next_count: got %0d want 0", ur); end
        ack_slot(1'b1, pn, pa);
        e = exp_ack(1'b1);
        n_chk++; if (pn !== e) begin n_fail++; $display("FAIL underrun_next_ack: got %b want %b", pn, e); end
    endtask

    task automatic test_nack();
        logic [7:0] seen; int ur; logic ak; logic [2:0] pn, pa, e; logic [7:0] b;
        clear();
        txen_in = 1'b1;
        push(8'($urandom));
        shift_byte(1'b0, 8'h00, seen, ur, ak);
        ack_slot(1'b0, pn, pa);
        e = exp_ack(1'b0);
        n_chk++; if (pn !== e) begin n_fail++; $display("FAIL nack_pulses: got %b want %b", pn, e); end
        txen_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc($urandom_range(0, 2));
            strobe_next();
            n_chk++; if (sda_out !== 1'b1) begin n_fail++; $display("FAIL nack_hold_sda[%0d]: got %b want 1", k, sda_out); end
        end
        ack_slot(1'b1, pn, pa);
        n_chk++; if ({pn, underrun_out} !== 4'b0000) begin n_fail++; $display("FAIL nack_hold_sample: got %b want 0000", {pn, underrun_out}); end
        clear();
        txen_in = 1'b1;
        b = 8'($urandom);
        push(b);
        shift_byte(1'b0, 8'h00, seen, ur, ak);
        n_chk++; if (seen !== b) begin n_fail++; $display("FAIL nack_restart_bits: got %h want %h", seen, b); end
        ack_slot(1'b1, pn, pa);
        e = exp_ack(1'b1);
        n_chk++; if (pn !== e) begin n_fail++; $display("FAIL nack_restart_ack: got %b want %b", pn, e); end
    endtask

    task automatic test_abort();
        clear();
        txen_in = 1'b1;
        push(8'h00);
        for (int k = 0; k < 5; k++) strobe_next();
        push(8'h5A);
        n_chk++; if (data_ready_out !== 1'b0) begin n_fail++; $display("FAIL abort_buffered: got ready %b want 0", data_ready_out); end
        clear();
        n_chk++; if ({sda_out, data_ready_out} !== 2'b11) begin
            n_fail++; $display("FAIL abort_sda_ready: got %b want 11", {sda_out, data_ready_out}); end
        n_chk++; if ({byteok_out, frameok_out, nack_out, underrun_out} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_pulses: got %b want 0000", {byteok_out, frameok_out, nack_out, underrun_out}); end
        txen_in = 1'b0;
        strobe_next();
        n_chk++; if ({sda_out, underrun_out} !== 2'b10) begin
            n_fail++; $display("FAIL abort_idle_no_txen: got %b want 10", {sda_out, underrun_out}); end
        txen_in = 1'b1;
        strobe_next();
        n_chk++; if ({sda_out, underrun_out} !== 2'b11) begin
            n_fail++; $display("FAIL abort_restart_empty: got %b want 11", {sda_out, underrun_out}); end
    endtask

    task automatic test_random();
        logic [7:0] seen; int ur; logic ak; logic [2:0] pn, pa, e; logic [7:0] b; logic pushed, ack;
        clear();
        for (int k = 0; k < 24; k++) begin
            pushed = ($urandom_range(0, 3) != 0);
            b      = 8'($urandom);
            ack    = ($urandom_range(0, 4) != 0);
            txen_in = 1'b1;
            if (pushed) begin
                n_chk++; if (data_ready_out !== 1'b1) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want 1", k, data_ready_out); end
                push(b);
            end
            shift_byte(1'b0, 8'h00, seen, ur, ak);
            n_chk++; if (seen !== (pushed ? b : 8'hFF)) begin
                n_fail++; $display("FAIL rnd_bits[%0d]: got %h want %h", k, seen, (pushed ? b : 8'hFF)); end
            n_chk++; if (ur !== (pushed ? 0 : 1)) begin
                n_fail++; $display("FAIL rnd_underrun[%0d]: got %0d want %0d", k, ur, (pushed ? 0 : 1)); end
            n_chk++; if (ak !== 1'b1) begin n_fail++; $display("FAIL rnd_ackslot[%0d]: got %b want 1", k, ak); end
            ack_slot(ack, pn, pa);
            e = exp_ack(ack);
            n_chk++; if (pn !== e) begin n_fail++; $display("FAIL rnd_pulses[%0d]: got %b want %b", k, pn, e); end
            n_chk++; if (pa !== 3'b000) begin n_fail++; $display("FAIL rnd_pulse_width[%0d]: got %b want 000", k, pa); end
            if (!ack) clear();
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_full_frame();
        test_underrun();
        test_nack();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_tx_ctr.md
# i2c_tx_ctr

Transmit-side I2C slave bit/byte sequencer. It pairs with the receive-side counter in the I2C front end of the filter. For read transactions it serialises buffered bytes MSB-first onto SDA, one bit per SCL-falling strobe, then releases SDA for the master ACK/NACK slot. It reports byte and frame completion, and it substitutes 0xFF when no data is ready.

## Interface
- FRAME_BYTES, default 2: bytes per read frame (e.g. one 16-bit filter sample); legal range 1..255.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clr_in  in  1  synchronous clear from START/STOP detector; aborts any transfer.
- txen_in  in  1  slave addressed for read; examined only in IDLE.
- next_in  in  1  one-cycle strobe per SCL falling edge: drive next bit.
- sample_in  in  1  one-cycle strobe per SCL rising edge: sample SDA.
- sda_in  in  1  synchronised SDA line value, used in the ACK slot.
- data_in  in  8  parallel byte to transmit.
- data_valid_in  in  1  data_in valid.
- data_ready_out  out  1  holding buffer empty; the byte is accepted when valid and ready are both 1.
- sda_out  out  1  SDA drive value; 1 = released (open-drain high).
- byteok_out  out  1  one-cycle pulse: byte sent and ACKed.
- frameok_out  out  1  one-cycle pulse: FRAME_BYTES consecutive bytes ACKed.
- nack_out  out  1  one-cycle pulse: master NACKed a byte.
- underrun_out  out  1  one-cycle pulse: a byte load found the buffer empty.

## Operation
- Datapath:
  - 1-byte holding buffer `buf`, flag `buf_full`, 8-bit shift register `shreg`.
  - 3-bit `bitcnt` counts bits; byte counter `bytecnt` is $clog2(FRAME_BYTES+1) bits wide.
- data_ready_out = ~buf_full. A handshake in any state except during rst_n=0 or clr_in=1 writes `buf` and sets buf_full.
- Load event: moves `buf` to `shreg` and clears buf_full.
  - If buf_full=0 at that moment, `shreg` is loaded with 8'hFF and underrun_out pulses.
  - A handshake in the same cycle as a load with buf_full=0 fills the buffer for the next byte; it is not used for the current one.
- States: IDLE, SHIFT, ACK, HOLD.
  - IDLE:
    - sda_out=1.
    - next_in with txen_in=1 triggers a load; set bitcnt=0 and go to SHIFT.
    - sda_out = new shreg[7].
  - SHIFT:
    - sda_out = shreg[7].
    - On next_in with bitcnt<7: shift left, bitcnt+1.
    - On next_in with bitcnt=7: sda_out=1, go to ACK.
  - ACK:
    - On sample_in with sda_in=0: byteok_out pulses and bytecnt+1.
      - If the new count equals FRAME_BYTES, frameok_out pulses in the same cycle and bytecnt=0.
      - Then wait for next_in, which triggers a load, sets bitcnt=0 and goes to SHIFT.
    - On sample_in with sda_in=1: nack_out pulses, bytecnt=0, go to HOLD.
  - HOLD: sda_out=1; ignores next_in and sample_in; leaves only via clr_in to IDLE.
- clr_in:
  - State→IDLE; bitcnt, bytecnt, buf_full → 0; sda_out=1.
  - No pulses are generated in that cycle.
- Priority: rst_n > clr_in > next_in/sample_in > handshake.
- sample_in outside ACK, and next_in in HOLD, are ignored.
- next_in and sample_in are never simultaneous; an SVA bind module checks this.
- txen_in deasserted mid-frame has no effect until the state returns to IDLE.

## Timing
- All outputs are registered. Reset values:
  - sda_out=1, byteok_out=0, frameok_out=0, nack_out=0, underrun_out=0.
  - data_ready_out=1, since buf_full=0.
- sda_out changes in the cycle after a next_in strobe (latency 1).
- byteok_out, frameok_out and nack_out assert in the cycle after the sample_in strobe (latency 1), high for exactly one cycle.
- underrun_out asserts in the cycle after the next_in that caused the load.
- data_ready_out falls in the cycle after a handshake, and rises in the cycle after a load empties the buffer.
- One byte = 8 next_in strobes in SHIFT, plus 1 next_in into ACK, plus 1 sample_in.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles with strobes active.
  - Required: sda_out=1, all pulses 0, data_ready_out=1.
- Single byte, ACK:
  - Stimulus: buffer 8'hA5, txen_in=1, 9 next_in strobes with sample_in between.
  - Required: sda_out sequence 1,0,1,0,0,1,0,1 then 1 in the ACK slot.
  - Required: on sample_in with sda_in=0, byteok_out is one pulse; frameok_out stays 0 (FRAME_BYTES=2).
- Full frame:
  - Stimulus: bytes 8'h12, 8'h34, both ACKed.
  - Required: byteok_out pulses twice; frameok_out pulses together with the second byteok_out; bytecnt wraps to 0.
- Underrun:
  - Stimulus: no data_valid_in before the first next_in.
  - Required: underrun_out pulses once; 8 bits of 1 on sda_out; the byte is still ACKable.
- NACK:
  - Stimulus: sda_in=1 in the ACK slot.
  - Required: nack_out pulses and no byteok_out.
  - Required: further next_in strobes leave sda_out=1 until clr_in, after which txen_in with next_in restarts transmission.
- Abort:
  - Stimulus: clr_in at bitcnt=4 with a byte buffered.
  - Required: next cycle shows sda_out=1, data_ready_out=1, state IDLE, and no pulses.
